// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_ctrl_if
//  Brief    : Button/prescaler/counter/display bundle for the stopwatch sequencer
//  Revision : 1.0
// ============================================================================
interface stopwatch_ctrl_if;
  logic       start_btn;
  logic       lap_btn;
  logic       tick;
  logic [2:0] cnt_tens;
  logic [3:0] cnt_ones;
  logic       cnt_en;
  logic       cnt_clr;
  logic       presc_clr;
  logic [2:0] disp_tens;
  logic [3:0] disp_ones;
  logic       running;
  logic       lap_active;
  logic       at_limit;

  modport master (
    output start_btn, lap_btn, tick, cnt_tens, cnt_ones,
    input  cnt_en, cnt_clr, presc_clr, disp_tens, disp_ones,
           running, lap_active, at_limit
  );

  modport slave (
    input  start_btn, lap_btn, tick, cnt_tens, cnt_ones,
    output cnt_en, cnt_clr, presc_clr, disp_tens, disp_ones,
           running, lap_active, at_limit
  );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_ctrl
//  Brief    : Run/pause/lap/clear sequencer and lap-display freeze for a 00-59 s stopwatch
//  Revision : 1.0
// ============================================================================
module stopwatch_ctrl #(
  parameter int LAP_SHOW = 5,
  parameter bit WRAP     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  stopwatch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_LAP    = 2'd2,
    S_PAUSED = 2'd3
  } state_t;

  localparam bit         c_timeout_en = (LAP_SHOW != 0);
  localparam logic [7:0] c_lap_last   = (LAP_SHOW == 0) ? 8'd0 : 8'(LAP_SHOW - 1);

  state_t     r_state;
  logic       r_start_q;
  logic       r_lap_q;
  logic [6:0] r_lap_reg;
  logic [7:0] r_lap_cnt;
  logic       r_at_limit;

  logic       w_start_e;
  logic       w_lap_e;
  logic       w_counting;
  logic       w_lim_stop;
  logic       w_clear;

  assign w_start_e  = bus.start_btn & ~r_start_q;
  assign w_lap_e    = bus.lap_btn & ~r_lap_q;
  assign w_counting = (r_state == S_RUN) || (r_state == S_LAP);
  assign w_lim_stop = (WRAP == 1'b0) && (bus.cnt_tens == 3'd5) && (bus.cnt_ones == 4'd9);
  // Start wins over a coincident lap press, so a clear needs lap alone.
  assign w_clear    = ~reset && (r_state == S_PAUSED) && w_lap_e && ~w_start_e;

  assign bus.cnt_en     = ~reset && bus.tick && w_counting && ~w_lim_stop;
  assign bus.cnt_clr    = w_clear;
  assign bus.presc_clr  = w_clear;
  assign bus.disp_tens  = (r_state == S_LAP) ? r_lap_reg[6:4] : bus.cnt_tens;
  assign bus.disp_ones  = (r_state == S_LAP) ? r_lap_reg[3:0] : bus.cnt_ones;
  assign bus.running    = w_counting;
  assign bus.lap_active = (r_state == S_LAP);
  assign bus.at_limit   = r_at_limit;

  always_ff @(posedge clk) begin
    // Edge detectors track the buttons through reset so a held button is not an edge.
    r_start_q <= bus.start_btn;
    r_lap_q   <= bus.lap_btn;
    if (reset) begin
      r_state    <= S_IDLE;
      r_lap_reg  <= 7'd0;
      r_lap_cnt  <= 8'd0;
      r_at_limit <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_e) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_start_e) begin
            r_state <= S_PAUSED;
          end else if (w_lap_e) begin
            r_state   <= S_LAP;
            r_lap_reg <= {bus.cnt_tens, bus.cnt_ones};
            r_lap_cnt <= 8'd0;
          end else if (bus.tick && w_lim_stop) begin
            r_state    <= S_PAUSED;
            r_at_limit <= 1'b1;
          end
        end
        S_LAP: begin
          if (w_start_e) begin
            r_state <= S_PAUSED;
          end else if (w_lap_e) begin
            r_state <= S_RUN;
          end else if (bus.tick) begin
            if (w_lim_stop) begin
              r_state    <= S_PAUSED;
              r_at_limit <= 1'b1;
            end else if (c_timeout_en && (r_lap_cnt == c_lap_last)) begin
              r_state <= S_RUN;
            end else begin
              r_lap_cnt <= r_lap_cnt + 8'd1;
            end
          end
        end
        S_PAUSED: begin
          if (w_start_e) begin
            r_state <= S_RUN;
          end else if (w_lap_e) begin
            r_state    <= S_IDLE;
            r_at_limit <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_ctrl
//  Brief    : Self-checking bench: two controller instances (wrapping with lap timeout,
//             stopping at 59 without timeout) against a seconds-level reference model
//  Revision : 1.0
// ============================================================================
module tb_stopwatch_ctrl;

  localparam int          c_idle     = 0;
  localparam int          c_run      = 1;
  localparam int          c_lap      = 2;
  localparam int          c_pause    = 3;
  localparam logic [12:0] c_rst_mask = 13'h1C00;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stopwatch_ctrl_if ifw ();
  stopwatch_ctrl_if ifn ();

  stopwatch_ctrl #(.LAP_SHOW(5), .WRAP(1'b1)) dut_w (.clk(clk), .reset(reset), .bus(ifw));
  stopwatch_ctrl #(.LAP_SHOW(0), .WRAP(1'b0)) dut_n (.clk(clk), .reset(reset), .bus(ifn));

  logic [12:0] obs_w, obs_n;
  assign obs_w = {ifw.cnt_en, ifw.cnt_clr, ifw.presc_clr, ifw.running, ifw.lap_active,
                  ifw.at_limit, ifw.disp_tens, ifw.disp_ones};
  assign obs_n = {ifn.cnt_en, ifn.cnt_clr, ifn.presc_clr, ifn.running, ifn.lap_active,
                  ifn.at_limit, ifn.disp_tens, ifn.disp_ones};

  // Reference model: seconds as an integer, a mode, the frozen lap seconds and its age.
  int          c_show [2] = '{5, 0};
  bit          c_wrap [2] = '{1'b1, 1'b0};
  int          m_mode [2];
  int          m_secs [2];
  int          m_lapv [2];
  int          m_age  [2];
  bit          m_lim  [2];
  bit          m_sq, m_lq;
  logic [12:0] e_v    [2];

  int n_run  = 0;
  int n_fail = 0;

  function automatic logic [12:0] obs_of(input int k);
    return (k == 0) ? obs_w : obs_n;
  endfunction

  // Drive one cycle of inputs, predict this cycle's outputs, then advance the model.
  task automatic step(input bit s, input bit l, input bit t, input bit r);
    bit se, le, lim, en, clr, counting;
    int dv, old;
    @(negedge clk);
    reset         = r;
    ifw.start_btn = s;  ifn.start_btn = s;
    ifw.lap_btn   = l;  ifn.lap_btn   = l;
    ifw.tick      = t;  ifn.tick      = t;
    ifw.cnt_tens  = 3'(m_secs[0] / 10);  ifw.cnt_ones = 4'(m_secs[0] % 10);
    ifn.cnt_tens  = 3'(m_secs[1] / 10);  ifn.cnt_ones = 4'(m_secs[1] % 10);
    #1;
    se = s && !m_sq && !r;
    le = l && !m_lq && !r;
    for (int k = 0; k < 2; k++) begin
      old      = m_secs[k];
      lim      = !c_wrap[k] && (old == 59);
      counting = (m_mode[k] == c_run) || (m_mode[k] == c_lap);
      en       = !r && t && counting && !lim;
      clr      = !r && (m_mode[k] == c_pause) && le && !se;
      dv       = (m_mode[k] == c_lap) ? m_lapv[k] : old;
      e_v[k]   = {en, clr, clr, counting, (m_mode[k] == c_lap), m_lim[k], 3'(dv / 10), 4'(dv % 10)};
      if (r) begin
        m_mode[k] = c_idle; m_lapv[k] = 0; m_age[k] = 0; m_lim[k] = 1'b0; m_secs[k] = 0;
      end else begin
        if (clr)     m_secs[k] = 0;
        else if (en) m_secs[k] = (old + 1) % 60;
        if (se) begin
          m_mode[k] = counting ? c_pause : c_run;
        end else if (le) begin
          if (m_mode[k] == c_run) begin
            m_mode[k] = c_lap; m_lapv[k] = old; m_age[k] = 0;
          end else if (m_mode[k] == c_lap) begin
            m_mode[k] = c_run;
          end else if (m_mode[k] == c_pause) begin
            m_mode[k] = c_idle; m_lim[k] = 1'b0;
          end
        end else if (t && counting) begin
          if (lim) begin
            m_mode[k] = c_pause; m_lim[k] = 1'b1;
          end else if (m_mode[k] == c_lap) begin
            if (c_show[k] != 0 && m_age[k] == c_show[k] - 1) m_mode[k] = c_run;
            else m_age[k]++;
          end
        end
      end
    end
    m_sq = s;
    m_lq = l;
  endtask

  task automatic test_reset();
    logic [3:0] seq [$] = '{4'b1000, 4'b1000, 4'b0000};
    foreach (seq[i]) begin
      logic [12:0] msk;
      step(seq[i][2], seq[i][1], seq[i][0], seq[i][3]);
      msk = seq[i][3] ? c_rst_mask : 13'h1FFF;
      for (int k = 0; k < 2; k++) begin
        n_run++;
        if ((obs_of(k) & msk) !== (e_v[k] & msk)) begin
          n_fail++;
          $display("FAIL reset[%0d] dut%0d: got %h, want %h", i, k, obs_of(k) & msk, e_v[k] & msk);
        end
      end
    end
    n_run++;
    if (obs_w !== 13'h0 || obs_n !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h/%h, want 0000/0000", obs_w, obs_n);
    end
  endtask

  task automatic test_run();
    logic [3:0] seq [$] = '{4'b0100, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    int ens = 0;
    foreach (seq[i]) begin
      step(seq[i][2], seq[i][1], seq[i][0], seq[i][3]);
      ens += int'(obs_w[12]);
      for (int k = 0; k < 2; k++) begin
        n_run++;
        if (obs_of(k) !== e_v[k]) begin
          n_fail++;
          $display("FAIL run[%0d] dut%0d: got %h, want %h", i, k, obs_of(k), e_v[k]);
        end
      end
    end
    n_run++;
    if (ens != 3 || ifw.running !== 1'b1 || ifw.disp_tens !== 3'd0 || ifw.disp_ones !== 4'd3) begin
      n_fail++;
      $display("FAIL run_summary: got en=%0d run=%b disp=%0d:%0d, want en=3 run=1 disp=0:3",
               ens, ifw.running, ifw.disp_tens, ifw.disp_ones);
    end
  endtask

  task automatic test_lap_freeze();
    logic [3:0] seq [$] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010,
                            4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
    foreach (seq[i]) begin
      step(seq[i][2], seq[i][1], seq[i][0], seq[i][3]);
      for (int k = 0; k < 2; k++) begin
        n_run++;
        if (obs_of(k) !== e_v[k]) begin
          n_fail++;
          $display("FAIL lap[%0d] dut%0d: got %h, want %h", i, k, obs_of(k), e_v[k]);
        end
      end
      if (i == 9) begin
        n_run++;
        if (ifw.lap_active !== 1'b1 || ifw.disp_tens !== 3'd0 || ifw.disp_ones !== 4'd7) begin
          n_fail++;
          $display("FAIL lap_hold: got lap=%b disp=%0d:%0d, want lap=1 disp=0:7",
                   ifw.lap_active, ifw.disp_tens, ifw.disp_ones);
        end
      end
    end
    n_run++;
    if (ifw.lap_active !== 1'b0 || ifw.disp_tens !== 3'd0 || ifw.disp_ones !== 4'd9) begin
      n_fail++;
      $display("FAIL lap_release: got lap=%b disp=%0d:%0d, want lap=0 disp=0:9",
               ifw.lap_active, ifw.disp_tens, ifw.disp_ones);
    end
  endtask

  task automatic test_lap_timeout();
    logic [3:0] seq [$] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0000,
                            4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
    foreach (seq[i]) begin
      step(seq[i][2], seq[i][1], seq[i][0], seq[i][3]);
      for (int k = 0; k < 2; k++) begin
        n_run++;
        if (obs_of(k) !== e_v[k]) begin
          n_fail++;
          $display("FAIL timeout[%0d] dut%0d: got %h, want %h", i, k, obs_of(k), e_v[k]);
        end
      end
      if (i == 10) begin
        n_run++;
        if (ifw.lap_active !== 1'b1 || ifw.disp_tens !== 3'd1 || ifw.disp_ones !== 4'd2) begin
          n_fail++;
          $display("FAIL timeout_4th: got lap=%b disp=%0d:%0d, want lap=1 disp=1:2",
                   ifw.lap_active, ifw.disp_tens, ifw.disp_ones);
        end
      end
    end
    n_run++;
    if (ifw.lap_active !== 1'b0 || ifw.disp_tens !== 3'd1 || ifw.disp_ones !== 4'd7 ||
        ifn.lap_active !== 1'b1 || ifn.disp_ones !== 4'd2) begin
      n_fail++;
      $display("FAIL timeout_5th: got w lap=%b disp=%0d:%0d n lap=%b ones=%0d, want w 0 1:7 n 1 2",
               ifw.lap_active, ifw.disp_tens, ifw.disp_ones, ifn.lap_active, ifn.disp_ones);
    end
  endtask

  task automatic test_pause_clear();
    logic [3:0] seq [$] = '{4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0001, 4'b0001,
                            4'b0000, 4'b0010, 4'b0000};
    int ens = 0;
    foreach (seq[i]) begin
      step(seq[i][2], seq[i][1], seq[i][0], seq[i][3]);
      if (i >= 3 && i <= 6) ens += int'(obs_w[12]) + int'(obs_n[12]);
      for (int k = 0; k < 2; k++) begin
        n_run++;
        if (obs_of(k) !== e_v[k]) begin
          n_fail++;
          $display("FAIL pause[%0d] dut%0d: got %h, want %h", i, k, obs_of(k), e_v[k]);
        end
      end
      if (i == 7) begin
        n_run++;
        if ({ifw.cnt_clr, ifw.presc_clr, ifn.cnt_clr, ifn.presc_clr} !== 4'b1111) begin
          n_fail++;
          $display("FAIL clear_pulse: got %b%b%b%b, want 1111",
                   ifw.cnt_clr, ifw.presc_clr, ifn.cnt_clr, ifn.presc_clr);
        end
      end
    end
    n_run++;
    if (ens != 0 || ifw.running !== 1'b0 || ifw.disp_tens !== 3'd0 || ifw.disp_ones !== 4'd0) begin
      n_fail++;
      $display("FAIL pause_idle: got en=%0d run=%b disp=%0d:%0d, want en=0 run=0 disp=0:0",
               ens, ifw.running, ifw.disp_tens, ifw.disp_ones);
    end
  endtask

  task automatic test_limit();
    for (int i = 0; i < 68; i++) begin
      bit s, l, t;
      s = (i == 0) || (i == 62);
      l = (i == 66);
      t = (i >= 2 && i <= 61) || (i == 64);
      step(s, l, t, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_run++;
        if (obs_of(k) !== e_v[k]) begin
          n_fail++;
          $display("FAIL limit[%0d] dut%0d: got %h, want %h", i, k, obs_of(k), e_v[k]);
        end
      end
      if (i == 61 || i == 64) begin
        n_run++;
        if (ifn.cnt_en !== 1'b0 || ifw.cnt_en !== (i == 61)) begin
          n_fail++;
          $display("FAIL limit_en[%0d]: got n=%b w=%b, want n=0 w=%b", i, ifn.cnt_en, ifw.cnt_en, i == 61);
        end
      end
      if (i == 62) begin
        n_run++;
        if (ifn.at_limit !== 1'b1 || ifn.running !== 1'b0 || ifw.disp_tens !== 3'd0 ||
            ifw.disp_ones !== 4'd0) begin
          n_fail++;
          $display("FAIL limit_stop: got lim=%b run=%b wdisp=%0d:%0d, want lim=1 run=0 wdisp=0:0",
                   ifn.at_limit, ifn.running, ifw.disp_tens, ifw.disp_ones);
        end
      end
    end
    n_run++;
    if (ifn.at_limit !== 1'b0 || ifn.running !== 1'b0) begin
      n_fail++;
      $display("FAIL limit_clear: got lim=%b run=%b, want lim=0 run=0", ifn.at_limit, ifn.running);
    end
  endtask

  task automatic test_simultaneous_reset();
    logic [3:0] seq [$] = '{4'b0100, 4'b0000, 4'b0001, 4'b0001, 4'b0010, 4'b0000, 4'b0001,
                            4'b0010, 4'b0000, 4'b0110, 4'b0000, 4'b0100, 4'b0000, 4'b0010,
                            4'b1110, 4'b0110, 4'b0110, 4'b0000};
    foreach (seq[i]) begin
      logic [12:0] msk;
      step(seq[i][2], seq[i][1], seq[i][0], seq[i][3]);
      msk = seq[i][3] ? c_rst_mask : 13'h1FFF;
      for (int k = 0; k < 2; k++) begin
        n_run++;
        if ((obs_of(k) & msk) !== (e_v[k] & msk)) begin
          n_fail++;
          $display("FAIL simul[%0d] dut%0d: got %h, want %h", i, k, obs_of(k) & msk, e_v[k] & msk);
        end
      end
      if (i == 10 || i == 16) begin
        n_run++;
        if ({ifw.running, ifw.lap_active, ifn.running, ifn.lap_active} !== 4'b0000) begin
          n_fail++;
          $display("FAIL simul_state[%0d]: got %b%b%b%b, want 0000",
                   i, ifw.running, ifw.lap_active, ifn.running, ifn.lap_active);
        end
      end
    end
  endtask

  task automatic test_random();
    bit s = 1'b0, l = 1'b0;
    for (int i = 0; i < 600; i++) begin
      bit t, r;
      logic [12:0] msk;
      if ($urandom_range(5) == 0) s = ~s;
      if ($urandom_range(5) == 0) l = ~l;
      t = ($urandom_range(2) == 0);
      r = ($urandom_range(149) == 0);
      step(s, l, t, r);
      msk = r ? c_rst_mask : 13'h1FFF;
      for (int k = 0; k < 2; k++) begin
        n_run++;
        if ((obs_of(k) & msk) !== (e_v[k] & msk)) begin
          n_fail++;
          $display("FAIL random[%0d] dut%0d: got %h, want %h", i, k, obs_of(k) & msk, e_v[k] & msk);
        end
      end
    end
  endtask

  initial begin
    ifw.start_btn = 1'b0; ifw.lap_btn = 1'b0; ifw.tick = 1'b0; ifw.cnt_tens = 3'd0; ifw.cnt_ones = 4'd0;
    ifn.start_btn = 1'b0; ifn.lap_btn = 1'b0; ifn.tick = 1'b0; ifn.cnt_tens = 3'd0; ifn.cnt_ones = 4'd0;
    m_sq = 1'b0; m_lq = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = c_idle; m_secs[k] = 0; m_lapv[k] = 0; m_age[k] = 0; m_lim[k] = 1'b0;
    end
    test_reset();
    test_run();
    test_lap_freeze();
    test_lap_timeout();
    test_pause_clear();
    test_limit();
    test_simultaneous_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
